uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the UART IP core. Consumes the 16x-oversampling tick from the baud rate generator and serializes one parallel byte per request as start bit, DBIT data bits LSB first, optional parity bit, and stop bit(s). Sits between the host-side TX FIFO/interface and the `tx` pin.

## Interface
- `DBIT`, 8: data bits per frame; legal values are 5–8.
- `SB_TICK`, 16: stop-bit length in s_ticks; legal values are 16 (1 stop bit), 24 (1.5) and 32 (2).
- `PARITY_ODD`, 0: with parity compiled in, 0 selects even parity and 1 selects odd; ignored otherwise.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `tx_start` in 1: request to send `din`; sampled only in IDLE.
- `s_tick` in 1: one-cycle oversampling tick from the baud generator (16 per bit).
- `din` in DBIT: byte to send; captured in the accept cycle.
- `tx` out 1: serial line, registered; reset value 1.
- `tx_busy` out 1: frame in progress; reset value 0.
- `tx_done_tick` out 1: one-cycle pulse at end of frame; reset value 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY (exists only with the macro), STOP.
- Tick counter `s` is 5 bits wide and increments only on `s_tick`. Bit counter `n` is 3 bits wide. Shift register `b` is DBIT wide.
- **IDLE:** `tx`=1. On `tx_start`: `b`<=`din`, `s`<=0, go to START.
- **START:** `tx`=0. On `s_tick` with `s`==15: `s`<=0, `n`<=0, go to DATA.
- **DATA:** `tx`=`b[0]`. On `s_tick` with `s`==15: `b`<=`b`>>1, `n`<=`n`+1.
  - If `n`==DBIT-1, go to PARITY, or to STOP when parity is compiled out.
- **PARITY:** `tx`=^captured byte XOR PARITY_ODD. On `s_tick` with `s`==15, go to STOP.
- **STOP:** `tx`=1. On `s_tick` with `s`==SB_TICK-1, go to IDLE and pulse `tx_done_tick`.
- Parity is computed from the byte captured at accept, not from `b` after shifting.
- `tx_start` outside IDLE is ignored and not queued.
- No `s_tick` means no progress: the FSM and counters hold indefinitely.
- `din` changes after the accept cycle have no effect on the frame.
- Reset low at any clock edge, including mid-frame, forces: IDLE, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, and all counters 0.

## Timing
- `tx`, `tx_busy` and `tx_done_tick` are registered; none of them is a combinational function of the inputs.
- Accept at edge k (IDLE and `tx_start`): from edge k+1, `tx`=0 and `tx_busy`=1.
- Each start, data and parity bit lasts exactly 16 `s_tick`s. The stop interval lasts SB_TICK `s_tick`s.
- With `s_tick` held high, `tx_done_tick` rises 1+16·(1+DBIT[+1])+SB_TICK cycles after the accept cycle. In that same cycle `tx_busy` falls and the FSM is in IDLE.
- `tx_start` high in the `tx_done_tick` cycle is accepted, giving back-to-back frames with no extra idle bit.
- `tx_done_tick` is high for exactly one cycle per frame.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state exists, the frame carries one parity bit between the data bits and stop, and `PARITY_ODD` selects the parity sense.
- **Undefined:** the PARITY state and its logic are absent, DATA goes straight to STOP, and `PARITY_ODD` has no effect.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding localparams (IDLE, START, DATA, PARITY, STOP), shared with the receiver.
  - The oversampling constant `OVERSAMPLE`=16.
  - The legal SB_TICK values.
- One natural sub-module, `uart_tx_bit_timer`: the tick counter `s` with clear, enable (`s_tick`) and a terminal-count compare against 15 or SB_TICK-1. The FSM stays in `uart_tx`.

## Test plan
- **Reset:** `reset`=0 for 3 cycles with `tx_start`=1 → `tx`=1, `tx_busy`=0, `tx_done_tick`=0 throughout, and no frame starts after release.
- **Basic frame:** `s_tick`=1 constantly, `din`=8'hA5, one `tx_start` pulse. Required:
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles.
  - `tx_done_tick` high exactly once, 161 cycles after accept.
- **Ignored and back-to-back starts:** `tx_start` held high through the whole frame with `din` changed mid-frame.
  - The frame still carries the originally captured 8'hA5.
  - The next frame starts in the `tx_done_tick` cycle with the new `din`.
- **Tick gaps:** `s_tick` every 4th cycle, and separately with a 100-cycle dropout mid-DATA → the bit widths are exactly 16 ticks and the data is uncorrupted.
- **Mid-frame reset:** reset asserted during data bit 3 → the next cycle shows `tx`=1, `tx_busy`=0 and no `tx_done_tick`; a new frame then completes normally.
- **Parity:** with `UART_TX_PARITY_EN` and `din`=8'hA5 → parity bit 0 when `PARITY_ODD`=0 and 1 when `PARITY_ODD`=1; frame length is 177 cycles.
- **Stop length:** `SB_TICK`=32, no parity → the stop interval is 32 cycles and done comes 177 cycles after accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate, legal stop lengths.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;

  localparam int unsigned SB_TICK_1P0 = 16;
  localparam int unsigned SB_TICK_1P5 = 24;
  localparam int unsigned SB_TICK_2P0 = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  // True for the supported stop lengths (1, 1.5 and 2 stop bits).
  function automatic bit sb_tick_legal(input int unsigned sb);
    return (sb == SB_TICK_1P0) || (sb == SB_TICK_1P5) || (sb == SB_TICK_2P0);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Oversampling tick counter for uart_tx: counts s_tick and flags the last
// tick of a bit (16) or of the stop interval (SB_TICK).
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned SB_TICK = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_stop,
  output logic o_tc_c
);

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);

  logic [4:0] r_s;
  logic [4:0] w_last;

  assign w_last = i_stop ? STOP_LAST : BIT_LAST;
  assign o_tc_c = i_en && (r_s == w_last);

  // Tick counter; wraps to 0 on terminal count so every interval starts clean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s <= 5'd0;
    end else if (i_clr || o_tc_c) begin
      r_s <= 5'd0;
    end else if (i_en) begin
      r_s <= r_s + 5'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  if (DBIT < 5 || DBIT > 8 || !sb_tick_legal(SB_TICK) || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: illegal DBIT/SB_TICK/PARITY_ODD");
  end

  uart_state_e     r_state, w_state_next;
  logic [2:0]      r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next;
  logic            r_tx, r_busy, r_done;
  logic            w_tx_next, w_done_next;
  logic            w_clr, w_tc, w_stop;
`ifdef UART_TX_PARITY_EN
  logic            r_par, w_par_next;
`endif

  assign w_stop = (r_state == STOP);

  uart_tx_bit_timer #(.SB_TICK(SB_TICK)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (s_tick),
    .i_stop (w_stop),
    .o_tc_c (w_tc)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_clr        = 1'b0;
    w_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (tx_start) begin
          w_b_next     = din;
          w_state_next = START;
`ifdef UART_TX_PARITY_EN
          w_par_next   = (^din) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (w_tc) begin
          w_n_next     = 3'd0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_tc) begin
          w_b_next = r_b >> 1;
          w_n_next = r_n + 3'd1;
          if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tc) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tc) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Line level follows the state being entered so tx is purely registered.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = w_par_next;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_n     <= 3'd0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (1 stop even, 2 stop even, 1 stop odd).
module tb_uart_tx;

  localparam int unsigned DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NPAR  = 1;
  localparam int          LEN16 = 177;
  localparam int          LEN32 = 193;
`else
  localparam int unsigned NPAR  = 0;
  localparam int          LEN16 = 161;
  localparam int          LEN32 = 177;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic [7:0] din;
  logic [2:0] start_v;
  wire  [2:0] tx_w, busy_w, done_w;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_start(start_v[0]), .s_tick(s_tick), .din(din),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));

  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(start_v[1]), .s_tick(s_tick), .din(din),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(start_v[2]), .s_tick(s_tick), .din(din),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level after t ticks of a frame carrying d.
  function automatic logic exp_level(input logic [7:0] d, input int t, input bit odd);
    int j;
    j = t / 16;
    if (j == 0) return 1'b0;
    if (j <= int'(DBIT)) return d[j-1];
    if (NPAR == 1 && j == int'(DBIT) + 1) return (^d) ^ odd;
    return 1'b1;
  endfunction

  task automatic accept(input int sel, input logic [7:0] d);
    din          = d;
    start_v[sel] = 1'b1;
    s_tick       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Checks every cycle of one frame, starting in the cycle after accept.
  task automatic frame_check(input int sel, input logic [7:0] d, input int sb, input int exp_len,
                             input int period, input int drop_at, input int drop_len,
                             input bit hold, input int din_at, input logic [7:0] new_din,
                             input int abort_at);
    int t;
    int total;
    bit odd;
    bit finished;
    t        = 0;
    total    = 16 * (1 + int'(DBIT) + int'(NPAR)) + sb;
    odd      = (sel == 2);
    finished = 1'b0;
    start_v[sel] = hold;
    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      if (abort_at != 0 && cyc == abort_at) begin
        reset  = 1'b0;
        s_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx", 32'(tx_w[sel]), 32'd1);
        chk("abort_busy", 32'(busy_w[sel]), 32'd0);
        chk("abort_done", 32'(done_w[sel]), 32'd0);
        reset    = 1'b1;
        finished = 1'b1;
      end else if (t == total) begin
        chk("done_tick", 32'(done_w[sel]), 32'd1);
        chk("done_busy", 32'(busy_w[sel]), 32'd0);
        chk("done_tx", 32'(tx_w[sel]), 32'd1);
        if (period == 1 && drop_len == 0) chk("frame_len", 32'(cyc), 32'(exp_len));
        finished = 1'b1;
        s_tick   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
          chk("b2b_tx", 32'(tx_w[sel]), 32'd0);
          chk("b2b_busy", 32'(busy_w[sel]), 32'd1);
        end else begin
          chk("post_busy", 32'(busy_w[sel]), 32'd0);
        end
        chk("done_once", 32'(done_w[sel]), 32'd0);
      end else begin
        chk("tx_bit", 32'(tx_w[sel]), 32'(exp_level(d, t, odd)));
        chk("busy", 32'(busy_w[sel]), 32'd1);
        chk("no_done", 32'(done_w[sel]), 32'd0);
        if (cyc == din_at) din = new_din;
        s_tick = (period == 1) ? 1'b1 : ((cyc % period) == 0);
        if (drop_len > 0 && cyc >= drop_at && cyc < drop_at + drop_len) s_tick = 1'b0;
        @(posedge clk);
        if (s_tick) t++;
        @(negedge clk);
      end
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset   = 1'b0;
    start_v = 3'b111;
    s_tick  = 1'b1;
    din     = 8'hA5;

    // Reset held with tx_start high.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("rst_tx", 32'(tx_w[k]), 32'd1);
        chk("rst_busy", 32'(busy_w[k]), 32'd0);
        chk("rst_done", 32'(done_w[k]), 32'd0);
      end
    end
    reset   = 1'b1;
    start_v = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_tx", 32'(tx_w[0]), 32'd1);
      chk("post_rst_busy", 32'(busy_w[0]), 32'd0);
    end

    // Basic frame.
    accept(0, 8'hA5);
    frame_check(0, 8'hA5, 16, LEN16, 1, 0, 0, 1'b0, 0, 8'h00, 0);

    // tx_start held through frame, din changed mid-frame, back-to-back second frame.
    accept(0, 8'hA5);
    frame_check(0, 8'hA5, 16, LEN16, 1, 0, 0, 1'b1, 50, 8'h3C, 0);
    frame_check(0, 8'h3C, 16, LEN16, 1, 0, 0, 1'b0, 0, 8'h00, 0);

    // s_tick every 4th cycle.
    accept(0, 8'h5A);
    frame_check(0, 8'h5A, 16, 0, 4, 0, 0, 1'b0, 0, 8'h00, 0);

    // 100-cycle tick dropout mid-DATA.
    accept(0, 8'hC3);
    frame_check(0, 8'hC3, 16, 0, 1, 60, 100, 1'b0, 0, 8'h00, 0);

    // Reset during data bit 3, then idle, then a clean frame.
    accept(0, 8'hA5);
    frame_check(0, 8'hA5, 16, 0, 1, 0, 0, 1'b0, 0, 8'h00, 72);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_tx", 32'(tx_w[0]), 32'd1);
      chk("idle_busy", 32'(busy_w[0]), 32'd0);
      chk("idle_done", 32'(done_w[0]), 32'd0);
    end
    accept(0, 8'h96);
    frame_check(0, 8'h96, 16, LEN16, 1, 0, 0, 1'b0, 0, 8'h00, 0);

    // Two stop bits.
    accept(1, 8'hA5);
    frame_check(1, 8'hA5, 32, LEN32, 1, 0, 0, 1'b0, 0, 8'h00, 0);

    // Odd-parity instance (parity sense only matters when parity is compiled in).
    accept(2, 8'hA5);
    frame_check(2, 8'hA5, 16, LEN16, 1, 0, 0, 1'b0, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
